// File: rtl/riscv_hwloop_controller_if.sv
// Loop-setup handshake plus register-file write port of the hardware-loop
// controller.
//
// Handshake: a setup request moves across the interface on a rising clk edge
// where setup_valid_i and setup_ready_o are both high. A requester holds its
// fields stable while valid is high and ready is low. abort_i cancels a
// sequence that is already under way. It never blocks an accept.
interface riscv_hwloop_controller_if #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
);
    logic                  setup_valid_i;
    logic                  setup_ready_o;
    logic [N_REG_BITS-1:0] setup_regid_i;
    logic [31:0]           setup_start_i;
    logic [31:0]           setup_end_i;
    logic [31:0]           setup_cnt_i;
    logic                  abort_i;

    logic [31:0]           hwlp_start_data_o;
    logic [31:0]           hwlp_end_data_o;
    logic [31:0]           hwlp_cnt_data_o;
    logic [2:0]            hwlp_we_o;
    logic [N_REG_BITS-1:0] hwlp_regid_o;

    // Requester side: issues setups and observes the write port.
    modport master (
        output setup_valid_i, setup_regid_i, setup_start_i, setup_end_i,
               setup_cnt_i, abort_i,
        input  setup_ready_o, hwlp_start_data_o, hwlp_end_data_o,
               hwlp_cnt_data_o, hwlp_we_o, hwlp_regid_o
    );

    // Controller side.
    modport slave (
        input  setup_valid_i, setup_regid_i, setup_start_i, setup_end_i,
               setup_cnt_i, abort_i,
        output setup_ready_o, hwlp_start_data_o, hwlp_end_data_o,
               hwlp_cnt_data_o, hwlp_we_o, hwlp_regid_o
    );
endinterface

// File: rtl/riscv_hwloop_controller.sv
// Hardware-loop controller. It sequences loop-setup writes into the loop
// register file and detects loop ends against the fetch PC.
// Optional feature macro: RISCV_HWLP_FAST_SETUP_EN. When it is defined, the
// start, end and count fields are written together in a single cycle
// (IDLE -> WR_ALL -> IDLE). When it is not defined, they are written one per
// cycle.
// state_dbg exposes the setup FSM state for observation only.
module riscv_hwloop_controller #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_hwloop_controller_if.slave bus,
    input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
    input  logic [31:0]            pc_i,
    input  logic                   pc_valid_i,
    output logic                   jump_o,
    output logic [31:0]            jump_target_o,
    output logic [N_REGS-1:0]      hwlp_dec_cnt_o,
    output logic                   busy_o,
    output logic [1:0]             state_dbg
);

`ifdef RISCV_HWLP_FAST_SETUP_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_ALL = 2'd1
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_START = 2'd1,
        WR_END   = 2'd2,
        WR_CNT   = 2'd3
    } state_t;
`endif

    state_t                state_q;
    logic [2:0]            we_q;
    logic                  ready_q;
    logic [N_REG_BITS-1:0] regid_q;
    logic [31:0]           start_q;
    logic [31:0]           end_q;
    logic [31:0]           cnt_q;
    logic [N_REGS-1:0]     match;

    // The write enable is registered. An abort masks it combinationally so
    // that the aborted cycle writes nothing.
    assign bus.hwlp_we_o         = bus.abort_i ? 3'b000 : we_q;
    assign bus.setup_ready_o     = ready_q;
    assign bus.hwlp_start_data_o = start_q;
    assign bus.hwlp_end_data_o   = end_q;
    assign bus.hwlp_cnt_data_o   = cnt_q;
    assign bus.hwlp_regid_o      = regid_q;
    assign busy_o                = ~ready_q;
    assign state_dbg             = state_q;

    // Setup sequencer: accept one request, then step through the write phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 3'b000;
            ready_q <= 1'b1;
            regid_q <= '0;
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.setup_valid_i) begin
                        regid_q <= bus.setup_regid_i;
                        start_q <= bus.setup_start_i;
                        end_q   <= bus.setup_end_i;
                        cnt_q   <= bus.setup_cnt_i;
                        ready_q <= 1'b0;
`ifdef RISCV_HWLP_FAST_SETUP_EN
                        state_q <= WR_ALL;
                        we_q    <= 3'b111;
`else
                        state_q <= WR_START;
                        we_q    <= 3'b001;
`endif
                    end
                end
`ifdef RISCV_HWLP_FAST_SETUP_EN
                WR_ALL: begin
                    state_q <= IDLE;
                    we_q    <= 3'b000;
                    ready_q <= 1'b1;
                end
`else
                WR_START: begin
                    if (bus.abort_i) begin
                        state_q <= IDLE;
                        we_q    <= 3'b000;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= WR_END;
                        we_q    <= 3'b010;
                    end
                end
                WR_END: begin
                    if (bus.abort_i) begin
                        state_q <= IDLE;
                        we_q    <= 3'b000;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= WR_CNT;
                        we_q    <= 3'b100;
                    end
                end
                WR_CNT: begin
                    state_q <= IDLE;
                    we_q    <= 3'b000;
                    ready_q <= 1'b1;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    we_q    <= 3'b000;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Per-loop end match. A set that is being rewritten is ignored, so its
    // counter is never written and decremented in the same cycle.
    always_comb begin
        match = '0;
        for (int k = 0; k < N_REGS; k++) begin
            match[k] = pc_valid_i
                    && (pc_i == hwlp_end_addr_i[k])
                    && (hwlp_counter_i[k] != 32'd0)
                    && !(busy_o && (regid_q == N_REG_BITS'(k)));
        end
    end

    // Priority select. The scan runs downward, so the innermost (lowest)
    // matching set wins. A counter of 1 decrements without jumping, which
    // lets execution fall through.
    always_comb begin
        hwlp_dec_cnt_o = '0;
        jump_o         = 1'b0;
        jump_target_o  = 32'd0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (match[k]) begin
                hwlp_dec_cnt_o    = '0;
                hwlp_dec_cnt_o[k] = 1'b1;
                jump_o            = (hwlp_counter_i[k] != 32'd1);
                jump_target_o     = hwlp_start_addr_i[k];
            end
        end
    end

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Self-checking bench for riscv_hwloop_controller. Honours
// RISCV_HWLP_FAST_SETUP_EN when it is defined together with the RTL.
module tb_riscv_hwloop_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_hwloop_controller_if #(.N_REGS(2)) bus ();

    logic [1:0][31:0] rf_start;
    logic [1:0][31:0] rf_end;
    logic [1:0][31:0] rf_cnt;
    logic [31:0]      pc;
    logic             pc_valid;
    logic             jump;
    logic [31:0]      jump_target;
    logic [1:0]       dec;
    logic             busy;
    logic [1:0]       state_dbg;

    riscv_hwloop_controller #(.N_REGS(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .hwlp_start_addr_i (rf_start),
        .hwlp_end_addr_i   (rf_end),
        .hwlp_counter_i    (rf_cnt),
        .pc_i              (pc),
        .pc_valid_i        (pc_valid),
        .jump_o            (jump),
        .jump_target_o     (jump_target),
        .hwlp_dec_cnt_o    (dec),
        .busy_o            (busy),
        .state_dbg         (state_dbg)
    );

    int errors = 0;
    int checks = 0;

    // Write enables the register file should see after an accept, one per cycle.
    logic [2:0] wr_seq[$];
    // Scoreboard: write enables still expected for the setup in flight.
    logic [2:0] exp_q[$];

    // Wait for the edge, then step 1 time unit past it so inputs never
    // change exactly at the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for loop-end detection. It picks the first qualifying loop
    // index (innermost first).
    function automatic void model_detect(input logic busy_m, input logic regid_m,
                                         output logic j, output logic [31:0] t,
                                         output logic [1:0] d);
        int sel;
        sel = -1;
        for (int k = 0; k < 2; k++) begin
            if (sel < 0 && pc_valid && pc == rf_end[k] && rf_cnt[k] != 0
                && !(busy_m && int'(regid_m) == k))
                sel = k;
        end
        j = 1'b0;
        t = 32'd0;
        d = 2'b00;
        if (sel >= 0) begin
            d = 2'(1 << sel);
            t = rf_start[sel];
            j = (rf_cnt[sel] != 32'd1);
        end
    endfunction

    task automatic idle_inputs();
        bus.setup_valid_i = 1'b0;
        bus.setup_regid_i = 1'b0;
        bus.setup_start_i = 32'd0;
        bus.setup_end_i   = 32'd0;
        bus.setup_cnt_i   = 32'd0;
        bus.abort_i       = 1'b0;
        pc_valid          = 1'b0;
        pc                = 32'd0;
        rf_start          = '0;
        rf_end            = '0;
        rf_cnt            = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.setup_valid_i = 1'b1;  // reset must win over an accept
        bus.setup_start_i = 32'hDEAD_BEEF;
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.setup_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", bus.setup_ready_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (bus.hwlp_we_o !== 3'b000) begin errors++; $display("FAIL reset_we got=%b exp=000", bus.hwlp_we_o); end
        checks++; if (bus.hwlp_start_data_o !== 32'd0 || bus.hwlp_end_data_o !== 32'd0 || bus.hwlp_cnt_data_o !== 32'd0)
            begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.hwlp_start_data_o, bus.hwlp_end_data_o, bus.hwlp_cnt_data_o); end
        checks++; if (bus.hwlp_regid_o !== 1'b0) begin errors++; $display("FAIL reset_regid got=%0b exp=0", bus.hwlp_regid_o); end
        checks++; if (jump !== 1'b0 || dec !== 2'b00) begin errors++; $display("FAIL reset_detect jump=%0b dec=%b exp=0/00", jump, dec); end
        rst = 1'b0;
        bus.setup_valid_i = 1'b0;
        bus.setup_start_i = 32'd0;
        tick();
    endtask

    task automatic test_setup_sequence();
        int low;
        low = 0;
        bus.setup_valid_i = 1'b1;
        bus.setup_regid_i = 1'b1;
        bus.setup_start_i = 32'h100;
        bus.setup_end_i   = 32'h120;
        bus.setup_cnt_i   = 32'd5;
        tick();
        bus.setup_valid_i = 1'b0;
        bus.setup_start_i = $urandom;  // the latched values must not follow these
        bus.setup_end_i   = $urandom;
        bus.setup_cnt_i   = $urandom;
        for (int i = 0; i < wr_seq.size(); i++) begin
            @(negedge clk);
            if (bus.setup_ready_o === 1'b0) low++;
            checks++; if (bus.hwlp_we_o !== wr_seq[i]) begin errors++; $display("FAIL seq_we[%0d] got=%b exp=%b", i, bus.hwlp_we_o, wr_seq[i]); end
            checks++; if (bus.hwlp_regid_o !== 1'b1) begin errors++; $display("FAIL seq_regid got=%0b exp=1", bus.hwlp_regid_o); end
            checks++; if (bus.hwlp_start_data_o !== 32'h100 || bus.hwlp_end_data_o !== 32'h120 || bus.hwlp_cnt_data_o !== 32'd5)
                begin errors++; $display("FAIL seq_data got=%h/%h/%h exp=100/120/5", bus.hwlp_start_data_o, bus.hwlp_end_data_o, bus.hwlp_cnt_data_o); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy got=%0b exp=1", busy); end
            tick();
        end
        @(negedge clk);
`ifdef RISCV_HWLP_FAST_SETUP_EN
        checks++; if (low != 1) begin errors++; $display("FAIL seq_ready_low_cycles got=%0d exp=1", low); end
`else
        checks++; if (low != 3) begin errors++; $display("FAIL seq_ready_low_cycles got=%0d exp=3", low); end
`endif
        checks++; if (bus.setup_ready_o !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL seq_done ready=%0b busy=%0b exp=1/0", bus.setup_ready_o, busy); end
        checks++; if (bus.hwlp_we_o !== 3'b000) begin errors++; $display("FAIL seq_idle_we got=%b exp=000", bus.hwlp_we_o); end
        tick();
    endtask

    task automatic test_loop_back();
        rf_end   = {32'hDEAD_0000, 32'h120};
        rf_start = {32'h0000_0040, 32'h100};
        rf_cnt   = {32'd0, 32'd3};
        pc = 32'h120;
        pc_valid = 1'b1;
        @(negedge clk);
        checks++; if (jump !== 1'b1 || jump_target !== 32'h100 || dec !== 2'b01)
            begin errors++; $display("FAIL loop_cnt3 jump=%0b tgt=%h dec=%b exp=1/100/01", jump, jump_target, dec); end
        rf_cnt[0] = 32'd1;
        #1;
        checks++; if (jump !== 1'b0 || dec !== 2'b01)
            begin errors++; $display("FAIL loop_cnt1 jump=%0b dec=%b exp=0/01", jump, dec); end
        rf_cnt[0] = 32'd0;
        #1;
        checks++; if (jump !== 1'b0 || jump_target !== 32'd0 || dec !== 2'b00)
            begin errors++; $display("FAIL loop_cnt0 jump=%0b tgt=%h dec=%b exp=0/0/00", jump, jump_target, dec); end
        rf_cnt[0] = 32'hFFFF_FFFF;
        #1;
        checks++; if (jump !== 1'b1 || dec !== 2'b01)
            begin errors++; $display("FAIL loop_cntmax jump=%0b dec=%b exp=1/01", jump, dec); end
        pc_valid = 1'b0;
        #1;
        checks++; if (jump !== 1'b0 || dec !== 2'b00)
            begin errors++; $display("FAIL loop_pc_invalid jump=%0b dec=%b exp=0/00", jump, dec); end
        tick();
    endtask

    task automatic test_nested_priority();
        rf_end   = {32'h200, 32'h200};
        rf_start = {32'h140, 32'h180};
        rf_cnt   = {32'd7, 32'd4};
        pc = 32'h200;
        pc_valid = 1'b1;
        @(negedge clk);
        checks++; if (dec !== 2'b01 || jump_target !== 32'h180 || jump !== 1'b1)
            begin errors++; $display("FAIL nested_inner dec=%b tgt=%h jump=%0b exp=01/180/1", dec, jump_target, jump); end
        rf_cnt[0] = 32'd0;
        #1;
        checks++; if (dec !== 2'b10 || jump_target !== 32'h140 || jump !== 1'b1)
            begin errors++; $display("FAIL nested_outer dec=%b tgt=%h jump=%0b exp=10/140/1", dec, jump_target, jump); end
        pc_valid = 1'b0;
        tick();
    endtask

    task automatic test_busy_suppression();
        rf_end   = {32'h400, 32'h300};
        rf_start = {32'h3C0, 32'h2C0};
        rf_cnt   = {32'd3, 32'd2};
        pc_valid = 1'b1;
        bus.setup_valid_i = 1'b1;
        bus.setup_regid_i = 1'b0;
        bus.setup_start_i = 32'h500;
        bus.setup_end_i   = 32'h540;
        bus.setup_cnt_i   = 32'd9;
        tick();
        bus.setup_valid_i = 1'b0;
        for (int i = 0; i < wr_seq.size(); i++) begin
            @(negedge clk);
            pc = 32'h300;
            #1;
            checks++; if (jump !== 1'b0 || dec !== 2'b00)
                begin errors++; $display("FAIL busy_suppress[%0d] jump=%0b dec=%b exp=0/00", i, jump, dec); end
            pc = 32'h400;
            #1;
            checks++; if (jump !== 1'b1 || dec !== 2'b10 || jump_target !== 32'h3C0)
                begin errors++; $display("FAIL busy_other[%0d] jump=%0b dec=%b tgt=%h exp=1/10/3c0", i, jump, dec, jump_target); end
            tick();
        end
        pc = 32'h300;
        @(negedge clk);
        checks++; if (jump !== 1'b1 || dec !== 2'b01 || jump_target !== 32'h2C0)
            begin errors++; $display("FAIL busy_released jump=%0b dec=%b tgt=%h exp=1/01/2c0", jump, dec, jump_target); end
        pc_valid = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int abort_at;
        abort_at = (wr_seq.size() > 1) ? 1 : 0;  // WR_END, or WR_ALL when fast
        bus.setup_valid_i = 1'b1;
        bus.setup_regid_i = 1'b1;
        tick();
        bus.setup_valid_i = 1'b0;
        for (int i = 0; i <= abort_at; i++) begin
            if (i == abort_at) bus.abort_i = 1'b1;
            @(negedge clk);
            if (i == abort_at) begin
                checks++; if (bus.hwlp_we_o !== 3'b000 || busy !== 1'b1)
                    begin errors++; $display("FAIL abort_cycle we=%b busy=%0b exp=000/1", bus.hwlp_we_o, busy); end
            end else begin
                checks++; if (bus.hwlp_we_o !== wr_seq[i])
                    begin errors++; $display("FAIL abort_pre_we[%0d] got=%b exp=%b", i, bus.hwlp_we_o, wr_seq[i]); end
            end
            tick();
        end
        bus.abort_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.setup_ready_o !== 1'b1 || busy !== 1'b0 || bus.hwlp_we_o !== 3'b000)
            begin errors++; $display("FAIL abort_idle ready=%0b busy=%0b we=%b exp=1/0/000", bus.setup_ready_o, busy, bus.hwlp_we_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.hwlp_we_o !== 3'b000) begin errors++; $display("FAIL abort_no_late_write got=%b exp=000", bus.hwlp_we_o); end
        tick();
        // An abort that arrives in IDLE does not block an accept in the same cycle.
        bus.abort_i = 1'b1;
        bus.setup_valid_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.setup_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.hwlp_we_o !== wr_seq[0]) begin errors++; $display("FAIL abort_idle_accept got=%b exp=%b", bus.hwlp_we_o, wr_seq[0]); end
        for (int i = 0; i < wr_seq.size(); i++) tick();
    endtask

    task automatic test_reset_mid();
        bus.setup_valid_i = 1'b1;
        bus.setup_regid_i = 1'b1;
        bus.setup_start_i = 32'h1234;
        bus.setup_end_i   = 32'h5678;
        bus.setup_cnt_i   = 32'd11;
        tick();
        @(negedge clk);
        checks++; if (bus.hwlp_we_o !== wr_seq[0]) begin errors++; $display("FAIL rstmid_first_we got=%b exp=%b", bus.hwlp_we_o, wr_seq[0]); end
        rst = 1'b1;  // valid stays high: reset must still win
        tick();
        @(negedge clk);
        checks++; if (bus.setup_ready_o !== 1'b1 || busy !== 1'b0 || bus.hwlp_we_o !== 3'b000)
            begin errors++; $display("FAIL rstmid_ctrl ready=%0b busy=%0b we=%b exp=1/0/000", bus.setup_ready_o, busy, bus.hwlp_we_o); end
        checks++; if (bus.hwlp_start_data_o !== 32'd0 || bus.hwlp_end_data_o !== 32'd0 || bus.hwlp_cnt_data_o !== 32'd0 || bus.hwlp_regid_o !== 1'b0)
            begin errors++; $display("FAIL rstmid_data got=%h/%h/%h/%0b exp=0", bus.hwlp_start_data_o, bus.hwlp_end_data_o, bus.hwlp_cnt_data_o, bus.hwlp_regid_o); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic        m_regid;
        logic [31:0] m_start, m_end, m_cnt;
        logic        m_busy;
        logic [2:0]  e_we;
        logic        e_jump;
        logic [31:0] e_tgt;
        logic [1:0]  e_dec;
        int          pick;
        m_regid = 1'b0; m_start = 32'd0; m_end = 32'd0; m_cnt = 32'd0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.setup_valid_i = ($urandom_range(0, 2) == 0);
            bus.setup_regid_i = 1'($urandom_range(0, 1));
            bus.setup_start_i = $urandom;
            bus.setup_end_i   = $urandom;
            bus.setup_cnt_i   = $urandom;
            bus.abort_i       = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 2; k++) begin
                pick = $urandom_range(0, 2);
                rf_end[k]   = (pick == 0) ? 32'h1000 : (pick == 1) ? 32'h1004 : $urandom;
                rf_start[k] = $urandom;
                pick = $urandom_range(0, 3);
                rf_cnt[k]   = (pick == 0) ? 32'd0 : (pick == 1) ? 32'd1 : (pick == 2) ? 32'd2 : $urandom;
            end
            pick = $urandom_range(0, 2);
            pc = (pick == 0) ? rf_end[0] : (pick == 1) ? rf_end[1] : $urandom;
            pc_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            m_busy = (exp_q.size() != 0);
            e_we = (bus.abort_i || !m_busy) ? 3'b000 : exp_q[0];
            checks++; if (bus.hwlp_we_o !== e_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, bus.hwlp_we_o, e_we); end
            checks++; if (bus.setup_ready_o !== !m_busy || busy !== m_busy)
                begin errors++; $display("FAIL rnd_ready cyc=%0d ready=%0b busy=%0b exp_busy=%0b", cyc, bus.setup_ready_o, busy, m_busy); end
            checks++; if (bus.hwlp_regid_o !== m_regid || bus.hwlp_start_data_o !== m_start || bus.hwlp_end_data_o !== m_end || bus.hwlp_cnt_data_o !== m_cnt)
                begin errors++; $display("FAIL rnd_data cyc=%0d got=%0b/%h/%h/%h exp=%0b/%h/%h/%h", cyc, bus.hwlp_regid_o, bus.hwlp_start_data_o, bus.hwlp_end_data_o, bus.hwlp_cnt_data_o, m_regid, m_start, m_end, m_cnt); end
            model_detect(m_busy, m_regid, e_jump, e_tgt, e_dec);
            checks++; if (jump !== e_jump || jump_target !== e_tgt || dec !== e_dec)
                begin errors++; $display("FAIL rnd_detect cyc=%0d got=%0b/%h/%b exp=%0b/%h/%b", cyc, jump, jump_target, dec, e_jump, e_tgt, e_dec); end
            // Advance the reference across the coming edge.
            if (!m_busy) begin
                if (bus.setup_valid_i) begin
                    m_regid = bus.setup_regid_i;
                    m_start = bus.setup_start_i;
                    m_end   = bus.setup_end_i;
                    m_cnt   = bus.setup_cnt_i;
                    exp_q   = wr_seq;
                end
            end else if (bus.abort_i) begin
                exp_q.delete();
            end else begin
                void'(exp_q.pop_front());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
`ifdef RISCV_HWLP_FAST_SETUP_EN
        wr_seq = '{3'b111};
`else
        wr_seq = '{3'b001, 3'b010, 3'b100};
`endif
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_setup_sequence();
        test_loop_back();
        test_nested_priority();
        test_busy_suppression();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
